// File: rtl/instr_encoder_pkg.sv
// Shared MIPS opcode/funct constants, request kinds and encoder types.
// Used by the encoder and the boot/self-test instruction loader.
package instr_encoder_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL function codes
    localparam logic [5:0] FN_ADDU    = 6'h21;

    localparam logic [4:0] REG_ZERO   = 5'd0;

    // Request kinds shared with the loader; 5-7 are illegal
    typedef enum logic [2:0] {
        KIND_NATIVE = 3'd0,
        KIND_MOVE   = 3'd1,
        KIND_LI     = 3'd2,
        KIND_B      = 3'd3,
        KIND_BNEZ   = 3'd4
    } kind_e;

    typedef enum logic [1:0] {
        FMT_R,
        FMT_I,
        FMT_J,
        FMT_BAD
    } fmt_e;

    typedef enum logic {
        ST_IDLE,
        ST_LI_LO
    } state_e;

    typedef struct packed {
        logic [2:0]  kind;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] imm;
        logic [25:0] target;
    } enc_req_t;

    // FIFO payload: finished word plus end-of-request marker
    typedef struct packed {
        logic        last;
        logic [31:0] instr;
    } enc_word_t;

    localparam int WORD_W = $bits(enc_word_t);

    function automatic fmt_e op_format(input logic [5:0] op);
        fmt_e f;
        case (op)
            OP_SPECIAL: f = FMT_R;
            OP_ADDIU, OP_LUI, OP_LW, OP_LB,
            OP_SW, OP_SB, OP_REGIMM, OP_BNE,
            OP_BEQ, OP_BGTZ, OP_BLEZ, OP_ORI,
            OP_SLTI, OP_SLTIU: f = FMT_I;
            OP_J, OP_JAL: f = FMT_J;
            default: f = FMT_BAD;
        endcase
        return f;
    endfunction

    function automatic logic [31:0] enc_r(
        input logic [5:0] op,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [4:0] sh,
        input logic [5:0] fn
    );
        return {op, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(
        input logic [5:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(
        input logic [5:0]  op,
        input logic [25:0] tgt
    );
        return {op, tgt};
    endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Circular output FIFO for finished instruction words.
// Full is decoded from the registered count only.
module instr_fifo
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = WORD_W
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head word reads as zero while nothing is buffered
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage write; contents are don't-care until pushed
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since depth is a power of two
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs instruction field bundles into MIPS R/I/J words and expands
// move/li/b/bnez; finished words queue in a small output FIFO.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_kind,
    input  logic [5:0]  in_opcode,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [5:0]  in_funct,
    input  logic [31:0] in_imm,
    input  logic [25:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    enc_req_t    req;
    fmt_e        fmt;
    logic        legal;
    logic [31:0] word;

    state_e      state;
    state_e      state_n;
    logic [4:0]  li_rt;
    logic [15:0] li_imm;
    logic        latch_li;
    logic        err_n;

    logic        push;
    enc_word_t   push_word;
    enc_word_t   head;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_count;
    logic        unused_count;

    assign req = '{
        kind:   in_kind,
        opcode: in_opcode,
        rs:     in_rs,
        rt:     in_rt,
        rd:     in_rd,
        shamt:  in_shamt,
        funct:  in_funct,
        imm:    in_imm,
        target: in_target
    };

    assign fmt = op_format(req.opcode);

    // First (or only) word of the request and its legality
    always_comb begin
        legal = 1'b0;
        word  = '0;
        unique case (1'b1)
            (req.kind == KIND_NATIVE): begin
                unique case (fmt)
                    FMT_R: begin
                        legal = 1'b1;
                        word  = enc_r(req.opcode, req.rs, req.rt,
                                      req.rd, req.shamt, req.funct);
                    end
                    FMT_I: begin
                        legal = 1'b1;
                        word  = enc_i(req.opcode, req.rs, req.rt,
                                      req.imm[15:0]);
                    end
                    FMT_J: begin
                        legal = 1'b1;
                        word  = enc_j(req.opcode, req.target);
                    end
                    default: begin
                        legal = 1'b0;
                    end
                endcase
            end
            (req.kind == KIND_MOVE): begin
                legal = 1'b1;
                word  = enc_r(OP_SPECIAL, REG_ZERO, req.rs,
                              req.rd, 5'd0, FN_ADDU);
            end
            (req.kind == KIND_LI): begin
                legal = 1'b1;
                word  = enc_i(OP_LUI, REG_ZERO, req.rt,
                              req.imm[31:16]);
            end
            (req.kind == KIND_B): begin
                legal = 1'b1;
                word  = enc_i(OP_BEQ, REG_ZERO, REG_ZERO,
                              req.imm[15:0]);
            end
            (req.kind == KIND_BNEZ): begin
                legal = 1'b1;
                word  = enc_i(OP_BNE, REG_ZERO, req.rs,
                              req.imm[15:0]);
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Next state, handshake and FIFO push; ready never looks at in_valid
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        push      = 1'b0;
        push_word = '0;
        latch_li  = 1'b0;
        err_n     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = !fifo_full;
                if (in_valid && !fifo_full) begin
                    if (legal) begin
                        push            = 1'b1;
                        push_word.instr = word;
                        push_word.last  = (req.kind != KIND_LI);
                        if (req.kind == KIND_LI) begin
                            latch_li = 1'b1;
                            state_n  = ST_LI_LO;
                        end
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_LI_LO: begin
                if (!fifo_full) begin
                    push            = 1'b1;
                    push_word.instr = enc_i(OP_ORI, li_rt, li_rt, li_imm);
                    push_word.last  = 1'b1;
                    state_n         = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, LI low-half capture and registered error pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            li_rt  <= '0;
            li_imm <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_n;
            err   <= err_n;
            if (latch_li) begin
                li_rt  <= req.rt;
                li_imm <= req.imm[15:0];
            end
        end
    end

    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_word),
        .pop       (out_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign unused_count = ^fifo_count;

    assign out_valid = !fifo_empty;
    assign out_instr = head.instr;
    assign out_last  = head.last;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed requests push expected
// words; a negedge monitor pops and compares every output handshake.
module tb_instr_encoder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [5:0]  in_opcode;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [5:0]  in_funct;
    logic [31:0] in_imm;
    logic [25:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic        err;

    logic [32:0] exp_q[$];
    logic [32:0] exp_word;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          err_seen = 0;
    int          err_base;

    always #5 clock = ~clock;

    instr_encoder #(.FIFO_DEPTH(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_opcode (in_opcode),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_funct  (in_funct),
        .in_imm    (in_imm),
        .in_target (in_target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_last  (out_last),
        .err       (err)
    );

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Output monitor: every popped word must match the queue head
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word: got %h last %b, want none",
                         out_instr, out_last);
            end else begin
                exp_word = exp_q.pop_front();
                if ({out_last, out_instr} !== exp_word) begin
                    n_fail++;
                    $display("FAIL out_word: got %h last %b, want %h last %b",
                             out_instr, out_last,
                             exp_word[31:0], exp_word[32]);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (err) err_seen++;
    end

    task automatic send(input logic [2:0]  k,
                        input logic [5:0]  op,
                        input logic [4:0]  rs,
                        input logic [4:0]  rt,
                        input logic [4:0]  rd,
                        input logic [4:0]  sh,
                        input logic [5:0]  fn,
                        input logic [31:0] imm,
                        input logic [25:0] tgt);
        int n;
        in_kind   = k;
        in_opcode = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_shamt  = sh;
        in_funct  = fn;
        in_imm    = imm;
        in_target = tgt;
        in_valid  = 1'b1;
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready %b, want 1", in_ready);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_exp(input logic last, input logic [31:0] w);
        exp_q.push_back({last, w});
    endtask

    initial begin
        int n;
        in_valid  = 1'b0;
        in_kind   = '0;
        in_opcode = '0;
        in_rs     = '0;
        in_rt     = '0;
        in_rd     = '0;
        in_shamt  = '0;
        in_funct  = '0;
        in_imm    = '0;
        in_target = '0;
        out_ready = 1'b1;
        reset_n   = 1'b1;
        #1 reset_n = 1'b0;
        #11;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;

        // Native R-format, one cycle latency
        push_exp(1'b1, 32'h00221821);
        send(3'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 32'd0, 26'd0);
        check("native_latency_valid", 32'(out_valid), 32'd1);
        check("native_latency_instr", out_instr, 32'h00221821);

        // LI expands to LUI then ORI
        push_exp(1'b0, 32'h3C081234);
        push_exp(1'b1, 32'h35085678);
        send(3'd2, 6'h00, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00,
             32'h12345678, 26'd0);
        check("li_lo_in_ready", 32'(in_ready), 32'd0);
        check("li_lui_word", out_instr, 32'h3C081234);
        check("li_lui_last", 32'(out_last), 32'd0);
        @(posedge clock);
        #1;
        check("li_ori_word", out_instr, 32'h35085678);
        check("li_done_in_ready", 32'(in_ready), 32'd1);

        // J, BNEZ, MOVE, B, native I-format
        push_exp(1'b1, 32'h08100000);
        send(3'd0, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00,
             32'd0, 26'h0100000);
        push_exp(1'b1, 32'h1409FFFC);
        send(3'd4, 6'h00, 5'd9, 5'd0, 5'd0, 5'd0, 6'h00,
             32'h0000FFFC, 26'd0);
        push_exp(1'b1, 32'h00052021);
        send(3'd1, 6'h00, 5'd5, 5'd0, 5'd4, 5'd0, 6'h00, 32'd0, 26'd0);
        push_exp(1'b1, 32'h10000010);
        send(3'd3, 6'h00, 5'd7, 5'd7, 5'd0, 5'd0, 6'h00,
             32'hFFFF0010, 26'd0);
        push_exp(1'b1, 32'h27BDFFF8);
        send(3'd0, 6'h09, 5'd29, 5'd29, 5'd0, 5'd0, 6'h00,
             32'h0000FFF8, 26'd0);
        repeat (3) @(posedge clock);
        #1;

        // Illegal opcode and illegal kind
        err_base = err_seen;
        send(3'd0, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 6'h00, 32'd0, 26'd0);
        check("illegal_op_err", 32'(err), 32'd1);
        check("illegal_op_empty", 32'(out_valid), 32'd0);
        check("illegal_op_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        check("illegal_op_err_drop", 32'(err), 32'd0);
        send(3'd6, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 32'd0, 26'd0);
        check("illegal_kind_err", 32'(err), 32'd1);
        @(posedge clock);
        #1;
        check("illegal_kind_err_drop", 32'(err), 32'd0);
        check("illegal_kind_empty", 32'(out_valid), 32'd0);
        check("illegal_err_pulses", 32'(err_seen - err_base), 32'd2);

        // Backpressure: three words plus LUI fill the FIFO
        out_ready = 1'b0;
        push_exp(1'b1, 32'h00221821);
        send(3'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 32'd0, 26'd0);
        push_exp(1'b1, 32'h342200FF);
        send(3'd0, 6'h0D, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00,
             32'h000000FF, 26'd0);
        push_exp(1'b1, 32'h0FFFFFFF);
        send(3'd0, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00,
             32'd0, 26'h3FFFFFF);
        push_exp(1'b0, 32'h3C1FDEAD);
        push_exp(1'b1, 32'h37FFBEEF);
        send(3'd2, 6'h00, 5'd0, 5'd31, 5'd0, 5'd0, 6'h00,
             32'hDEADBEEF, 26'd0);
        repeat (3) @(posedge clock);
        #1;
        check("bp_hold_ready", 32'(in_ready), 32'd0);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_instr", out_instr, 32'h00221821);
        check("bp_hold_last", 32'(out_last), 32'd1);

        // One pop while full: the ORI push must wait a cycle
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check("bp_pop_blocks_push", 32'(in_ready), 32'd0);
        check("bp_head_after_pop", out_instr, 32'h342200FF);
        @(posedge clock);
        #1;
        check("bp_full_again_ready", 32'(in_ready), 32'd0);

        // Full in IDLE: a pending pop does not open in_ready
        push_exp(1'b1, 32'hAFBF0004);
        out_ready = 1'b1;
        in_kind   = 3'd0;
        in_opcode = 6'h2B;
        in_rs     = 5'd29;
        in_rt     = 5'd31;
        in_imm    = 32'd4;
        in_valid  = 1'b1;
        @(negedge clock);
        check("full_pop_no_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        send(3'd0, 6'h2B, 5'd29, 5'd31, 5'd0, 5'd0, 6'h00,
             32'd4, 26'd0);
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            n++;
            @(posedge clock);
        end
        #1;
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clock);
        #1;

        // Async reset while in LI_LO with two words buffered
        out_ready = 1'b0;
        send(3'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 32'd0, 26'd0);
        send(3'd2, 6'h00, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00,
             32'h12345678, 26'd0);
        check("rst_mid_li_lo", 32'(in_ready), 32'd0);
        check("rst_mid_valid_before", 32'(out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_instr", out_instr, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("rst_mid_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("rst_no_ori", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder: the inverse of the decode-stage classifier. It accepts instruction field bundles through a valid/ready handshake and packs each into 32-bit MIPS words in R-, I- or J-format. It expands the pseudo-instructions move, li, b and bnez into native words. Finished words are buffered in a small FIFO for the boot/self-test instruction loader. Opcodes outside the supported set are rejected with an error pulse.

## Interface
- FIFO_DEPTH, 4: output FIFO entries; power of two, at least 2.
- clock  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_kind  in  3  request kind: 0 NATIVE, 1 MOVE, 2 LI, 3 B, 4 BNEZ; values 5-7 are illegal.
- in_opcode  in  6  opcode; used for NATIVE only.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_funct  in  6  function field (R-format).
- in_imm  in  32  immediate; LI uses all 32 bits, other kinds use [15:0].
- in_target  in  26  jump target (J-format).
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  pop when out_valid && out_ready.
- out_instr  out  32  FIFO head word.
- out_last  out  1  head is the final word of its request.
- err  out  1  one-cycle pulse, the cycle after an illegal request is accepted.

## Operation
- NATIVE format selection by in_opcode:
  - SPECIAL gives R-format {op, rs, rt, rd, shamt, funct}.
  - ADDIU, LUI, LW, LB, SW, SB, REGIMM, BNE, BEQ, BGTZ, BLEZ, ORI, SLTI, SLTIU give I-format {op, rs, rt, imm[15:0]}.
  - J and JAL give J-format {op, target}.
  - Any other opcode is illegal.
- Pseudo-instruction expansion:
  - MOVE becomes addu rd, $zero, rs: {SPECIAL, 0, in_rs, in_rd, 0, ADDU funct 6'h21}.
  - B becomes beq $zero, $zero: {BEQ, 0, 0, imm[15:0]}.
  - BNEZ becomes bne $zero, rs: {BNE, 0, in_rs, imm[15:0]}.
  - LI expands to two words: {LUI, 0, in_rt, imm[31:16]}, then {ORI, in_rt, in_rt, imm[15:0]}.
- An illegal request (bad opcode or in_kind 5-7) is consumed, writes no word to the FIFO, and pulses err.
- Unused input fields are ignored. No field masking beyond the widths listed.
- State machine:
  - IDLE: in_ready = !fifo_full. An accepted LI pushes the LUI word with out_last=0, latches in_rt and imm[15:0], and goes to LI_LO. Every other accepted kind pushes one word with out_last=1 and stays in IDLE.
  - LI_LO: in_ready = 0. When !fifo_full, push the ORI word with out_last=1 and return to IDLE. Otherwise hold in LI_LO.
- FIFO:
  - Circular, with read and write pointers of log2(FIFO_DEPTH) bits that wrap to 0.
  - Occupancy count is log2(FIFO_DEPTH)+1 bits.
  - Push and pop in the same cycle leave the count unchanged.
  - fifo_full is decoded from the registered count only, so a same-cycle pop does not free a slot for a push.
  - Word order is strictly preserved.

## Timing
- Reset (asynchronous, reset_n low):
  - state = IDLE; pointers and count = 0.
  - out_valid = 0, out_instr = 0, out_last = 0, err = 0.
  - in_ready = 1 once reset_n is high.
- Reset mid-operation discards the LI_LO state and all buffered words.
- Latency: a word pushed at edge N is visible on out_instr/out_valid after edge N if the FIFO was empty.
- Throughput: one word per cycle. LI occupies the input for 2 cycles when there is no backpressure.
- out_instr and out_last are held stable while out_valid && !out_ready.
- in_ready is combinational from state and count only, never from in_valid.
- err is registered: it goes high the cycle after the illegal handshake, for exactly 1 cycle.

## Structure
- Opcode and funct constants (SPECIAL, ADDIU, LUI, ORI, BEQ, BNE, J, JAL, ADDU funct, etc.) come from the shared mips.h header. Do not use local literals for these.
- Add the in_kind encodings (KIND_NATIVE..KIND_BNEZ) to mips.h so loader and encoder share them.
- One sub-module: instr_fifo, parameterised on depth and width. Payload is 33 bits: instr plus last. It exposes full, empty and count.

## Test plan
- NATIVE: op 0, rs 1, rt 2, rd 3, shamt 0, funct 0x21 -> out_instr 0x00221821, out_last=1, one cycle after accept.
- LI: rt 8, imm 0x12345678 -> 0x3C081234 (last=0), then 0x35085678 (last=1). in_ready is low during LI_LO.
- J target 0x0100000 -> 0x08100000. BNEZ rs 9, imm 0xFFFC -> 0x1409FFFC. MOVE rd 4, rs 5 -> 0x00052021.
- Illegal opcode 0x3F, then in_kind 6 -> err pulses once per request, the FIFO stays empty, and in_ready stays high.
- Backpressure, out_ready=0:
  - Push 3 NATIVE words, then an LI. The LUI word fills the FIFO and the encoder holds in LI_LO.
  - Raise out_ready for one pop -> the ORI word is pushed the next cycle and order is preserved.
  - Also check that a simultaneous pop and push with the FIFO full is blocked.
- Assert reset_n low asynchronously while in LI_LO with 2 words buffered -> out_valid=0 immediately, no ORI word is emitted, and in_ready=1 after release.
